// File: rtl/divmul_iter.sv
// divmul_iter: multicycle signed divide / multiply unit feeding the HI/LO pair.
// One result bit per cycle on operand magnitudes, sign fix-up in a final cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; operands captured when start=1
//   S_RUN  | 32 iterations of shift-subtract (DIV) or shift-add (MULT)
//   S_FIX  | sign correction, hi/lo/div_zero registered, done pulsed
module divmul_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_op;
    logic        r_sa;
    logic        r_sb;
    logic        r_zero;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic [5:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [63:0] r_acc;
    logic        r_done;
    logic        r_div_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_b_zero;
    logic [32:0] w_rem_sh;
    logic        w_rem_ge;
    logic [31:0] w_rem_diff;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [32:0] w_add;
    logic [63:0] w_acc_nxt;
    logic [31:0] w_quo_signed;
    logic [31:0] w_rem_signed;
    logic [63:0] w_prod_signed;

    // Operand magnitudes; 0x80000000 maps to 2^31, which fits unsigned.
    assign w_abs_a  = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b  = b[31] ? (~b + 32'd1) : b;
    assign w_b_zero = (b == 32'd0);

    // Restoring division step: the dividend shifts out of r_quo MSB-first
    // while quotient bits shift in at the bottom. The shifted remainder needs
    // 33 bits; after a successful subtract it is always below |b|, so the
    // difference fits in 32 bits.
    assign w_rem_sh   = {r_rem, r_quo[31]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_rem_diff = w_rem_sh[31:0] - r_mag_b;
    assign w_rem_nxt  = w_rem_ge ? w_rem_diff : w_rem_sh[31:0];
    assign w_quo_nxt  = {r_quo[30:0], w_rem_ge};

    // Shift-add multiply step: the multiplier sits in the low half of the
    // accumulator and is consumed LSB-first as the product shifts in from above.
    assign w_add     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
    assign w_acc_nxt = {w_add, r_acc[31:1]};

    // Sign correction: quotient truncates toward zero, remainder follows a.
    assign w_quo_signed  = (r_sa ^ r_sb) ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_signed  = r_sa ? (~r_rem + 32'd1) : r_rem;
    assign w_prod_signed = (r_sa ^ r_sb) ? (~r_acc + 64'd1) : r_acc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; divide by zero skips the iterations entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!op && w_b_zero) w_state_nxt = S_FIX;
                    else                 w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == 6'd31) w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_zero     <= 1'b0;
            r_mag_a    <= 32'd0;
            r_mag_b    <= 32'd0;
            r_count    <= 6'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_acc      <= 64'd0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_sa    <= a[31];
                        r_sb    <= b[31];
                        r_zero  <= !op && w_b_zero;
                        r_mag_a <= w_abs_a;
                        r_mag_b <= w_abs_b;
                        r_count <= 6'd0;
                        r_rem   <= 32'd0;
                        r_quo   <= w_abs_a;
                        r_acc   <= {32'd0, w_abs_b};
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 6'd1;
                    if (r_op) begin
                        r_acc <= w_acc_nxt;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                    end
                end
                S_FIX: begin
                    r_done     <= 1'b1;
                    r_div_zero <= r_zero;
                    // On divide by zero hi/lo deliberately keep the old result.
                    if (!r_zero) begin
                        if (r_op) begin
                            r_hi <= w_prod_signed[63:32];
                            r_lo <= w_prod_signed[31:0];
                        end else begin
                            r_hi <= w_rem_signed;
                            r_lo <= w_quo_signed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_divmul_iter.sv
// Directed bench for divmul_iter: latency, signed results, divide by zero,
// ignored restart, and reset abort.
module tb_divmul_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int lat;

    divmul_iter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Tick until done rises; lat carries the edge number (edge 1 = start edge).
    task automatic wait_done(input int from, output int edge_no);
        edge_no = from;
        while (!done && edge_no < 120) begin
            tick();
            edge_no++;
        end
    endtask

    // Start an op at edge 1 and wait for done; returns the done edge number.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          output int edge_no);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = ~o;
        chk("busy_after_edge1", {63'd0, busy}, 64'd1);
        wait_done(1, edge_no);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz",   {63'd0, div_zero}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        // DIV 7 / 2
        run_op(1'b0, 32'd7, 32'd2, lat);
        chk("div7_2_lat", lat, 34);
        chk("div7_2_busy", {63'd0, busy}, 64'd0);
        chk("div7_2_hilo", {hi, lo}, {32'd1, 32'd3});
        chk("div7_2_dz", {63'd0, div_zero}, 64'd0);
        tick();
        chk("div7_2_done_fall", {63'd0, done}, 64'd0);
        chk("div7_2_hold", {hi, lo}, {32'd1, 32'd3});

        // DIV -7 / 2
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat);
        chk("divm7_2_lat", lat, 34);
        chk("divm7_2_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Overflow case
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("divovf_hilo", {hi, lo}, {32'h0000_0000, 32'h8000_0000});
        chk("divovf_dz", {63'd0, div_zero}, 64'd0);

        // MULT -1 x 2
        run_op(1'b1, 32'hFFFF_FFFF, 32'd2, lat);
        chk("mulm1_2_lat", lat, 34);
        chk("mulm1_2_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});

        // MULT min x min
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat);
        chk("mulmin_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

        // Divide by zero after a hi=1, lo=3 result, then back-to-back DIV 9/3
        run_op(1'b0, 32'd7, 32'd2, lat);
        run_op(1'b0, 32'd5, 32'd0, lat);
        chk("dz_lat", lat, 2);
        chk("dz_flag", {63'd0, div_zero}, 64'd1);
        chk("dz_busy", {63'd0, busy}, 64'd0);
        chk("dz_hilo_kept", {hi, lo}, {32'd1, 32'd3});
        run_op(1'b0, 32'd9, 32'd3, lat);
        chk("div9_3_lat", lat, 34);
        chk("div9_3_dz", {63'd0, div_zero}, 64'd0);
        chk("div9_3_hilo", {hi, lo}, {32'd0, 32'd3});

        // MULT 3 x 4 with a second start at edge 10 and garbage operands
        op = 1'b1; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0; a = 32'hFFFF_0000; b = 32'h7777_7777; op = 1'b0;
        for (int i = 2; i <= 9; i++) tick();
        start = 1'b1; op = 1'b0; a = 32'd100; b = 32'd0;
        tick();
        start = 1'b0;
        chk("restart_busy", {63'd0, busy}, 64'd1);
        wait_done(10, lat);
        chk("restart_lat", lat, 34);
        chk("restart_hilo", {hi, lo}, {32'd0, 32'd12});
        chk("restart_dz", {63'd0, div_zero}, 64'd0);

        // Reset at edge 20 of a DIV, new start at edge 22 completes at edge 55
        op = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 2; i <= 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        tick();
        op = 1'b0; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(22, lat);
        chk("after_abort_lat", lat, 55);
        chk("after_abort_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
